// File: rtl/rob_commit_unit_pkg.sv
// Shared definitions for the reorder-buffer ring and its commit stage:
// entry field layout and the commit FSM state encoding.
package rob_commit_unit_pkg;

    localparam int ENTRY_W   = 16;
    localparam int DONE_BIT  = ENTRY_W - 1;
    localparam int EXC_BIT   = ENTRY_W - 2;
    localparam int PAYLOAD_W = ENTRY_W - 2;
    localparam int STATE_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/rob_commit_unit_regs.sv
// Generic storage cells shared across the codebase: a plain register with
// synchronous reset, and a load-enabled register with synchronous reset.
module rob_rst_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset) q <= RST_VAL;
        else       q <= d;
    end
endmodule

module rob_en_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/rob_commit_unit.sv
// In-order commit stage: retires done heads of the reorder buffer into a
// one-entry output register, and drains the buffer after an exception.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter int ENTRY_BITWIDTH = ENTRY_W,
    parameter int CNT_NBITS      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      head_peek_call,
    input  logic                      head_peek_rdy,
    input  logic [ENTRY_BITWIDTH-1:0] head_peek_value,
    output logic                      head_remove_call,
    input  logic                      head_remove_rdy,
    output logic                      commit_call,
    input  logic                      commit_rdy,
    output logic [ENTRY_BITWIDTH-3:0] commit_value,
    output logic                      flush_call,
    output logic                      alloc_stall,
    output logic [CNT_NBITS-1:0]      retired_count,
    output logic [CNT_NBITS-1:0]      flushed_count
);
    // Status fields stay anchored to the top of the entry for any width.
    localparam int DONE_IDX = DONE_BIT - ENTRY_W + ENTRY_BITWIDTH;
    localparam int EXC_IDX  = EXC_BIT  - ENTRY_W + ENTRY_BITWIDTH;
    localparam int PW       = ENTRY_BITWIDTH - 2;

    logic [STATE_W-1:0] state_bits;
    state_t             state_reg;
    state_t             state_next;
    logic               out_valid_reg;
    logic               out_valid_next;
    logic [PW-1:0]      out_payload_reg;
    logic               head_done;
    logic               head_exc;
    logic               slot_free;
    logic               retire;
    logic               flush_inc;
    logic [1:0]         cnt_inc;
    logic [CNT_NBITS-1:0] cnt_reg  [2];
    logic [CNT_NBITS-1:0] cnt_next [2];

    assign state_reg = state_t'(state_bits);
    assign head_done = head_peek_value[DONE_IDX];
    assign head_exc  = head_peek_value[EXC_IDX];
    assign slot_free = !out_valid_reg || (out_valid_reg && commit_rdy);

    assign head_peek_call = head_peek_rdy;
    assign commit_call    = out_valid_reg;
    assign commit_value   = out_payload_reg;

    always_comb begin
        state_next       = state_reg;
        head_remove_call = 1'b0;
        flush_call       = 1'b0;
        alloc_stall      = 1'b0;
        retire           = 1'b0;
        flush_inc        = 1'b0;
        case (state_reg)
            RUN: begin
                if (head_peek_rdy && head_remove_rdy && head_done) begin
                    if (!head_exc) begin
                        if (slot_free) begin
                            retire           = 1'b1;
                            head_remove_call = 1'b1;
                        end
                    // Exception waits until every older retirement is delivered.
                    end else if (!out_valid_reg) begin
                        head_remove_call = 1'b1;
                        flush_call       = 1'b1;
                        flush_inc        = 1'b1;
                        state_next       = DRAIN;
                    end
                end
            end
            DRAIN: begin
                alloc_stall = 1'b1;
                if (!head_peek_rdy) begin
                    state_next = FLUSH;
                end else if (head_remove_rdy) begin
                    head_remove_call = 1'b1;
                    flush_inc        = 1'b1;
                end
            end
            FLUSH: begin
                alloc_stall = 1'b1;
                state_next  = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // A retire in the same cycle as an accept keeps the slot occupied.
    assign out_valid_next = retire | (out_valid_reg & ~commit_rdy);

    rob_rst_reg #(.W(STATE_W), .RST_VAL(STATE_W'(RUN))) u_state_reg (
        .clk   (clk),
        .reset (reset),
        .d     (state_next),
        .q     (state_bits)
    );

    rob_rst_reg #(.W(1), .RST_VAL(1'b0)) u_out_valid_reg (
        .clk   (clk),
        .reset (reset),
        .d     (out_valid_next),
        .q     (out_valid_reg)
    );

    rob_en_reg #(.W(PW)) u_out_payload_reg (
        .clk   (clk),
        .reset (reset),
        .en    (retire),
        .d     (head_peek_value[PW-1:0]),
        .q     (out_payload_reg)
    );

    assign cnt_inc = {flush_inc, retire};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            assign cnt_next[gi] = cnt_reg[gi] + CNT_NBITS'(cnt_inc[gi]);
            rob_rst_reg #(.W(CNT_NBITS), .RST_VAL('0)) u_cnt_reg (
                .clk   (clk),
                .reset (reset),
                .d     (cnt_next[gi]),
                .q     (cnt_reg[gi])
            );
        end
    endgenerate

    assign retired_count = cnt_reg[0];
    assign flushed_count = cnt_reg[1];

endmodule

// File: tb/tb_rob_commit_unit.sv
// Bench for rob_commit_unit: directed scenarios followed by random traffic,
// checked against a queue-based model of the buffer and commit stream.
module tb_rob_commit_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        head_peek_call;
    logic        head_peek_rdy = 1'b0;
    logic [15:0] head_peek_value = 16'h0;
    logic        head_remove_call;
    logic        head_remove_rdy = 1'b0;
    logic        commit_call;
    logic        commit_rdy = 1'b0;
    logic [13:0] commit_value;
    logic        flush_call;
    logic        alloc_stall;
    logic [15:0] retired_count;
    logic [15:0] flushed_count;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [15:0] buf_q[$];
    logic [13:0] exp_q[$];
    int          commit_cycles[$];
    int          mode = 0;          // 0 normal, 1 draining, 2 single flush cycle
    int unsigned exp_ret = 0;
    int unsigned exp_fl  = 0;
    logic        prev_stalled = 1'b0;
    logic [13:0] prev_value = '0;

    rob_commit_unit dut (
        .clk              (clk),
        .reset            (reset),
        .head_peek_call   (head_peek_call),
        .head_peek_rdy    (head_peek_rdy),
        .head_peek_value  (head_peek_value),
        .head_remove_call (head_remove_call),
        .head_remove_rdy  (head_remove_rdy),
        .commit_call      (commit_call),
        .commit_rdy       (commit_rdy),
        .commit_value     (commit_value),
        .flush_call       (flush_call),
        .alloc_stall      (alloc_stall),
        .retired_count    (retired_count),
        .flushed_count    (flushed_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    // One clock of traffic: drive at negedge, check and update the model
    // mid-cycle, then check the counters just after the rising edge.
    task automatic step(input logic crdy, input logic rrdy);
        logic [15:0] h;
        logic [13:0] want;
        logic        exp_rm;
        int          next_mode;
        @(negedge clk);
        commit_rdy      = crdy;
        head_remove_rdy = rrdy;
        head_peek_rdy   = (buf_q.size() != 0);
        head_peek_value = (buf_q.size() != 0) ? buf_q[0] : 16'h0;
        #1;
        cycle++;
        h = head_peek_value;
        next_mode = mode;
        chk("peek_call", 32'(head_peek_call), 32'(head_peek_rdy));
        if (head_remove_call)
            chk("remove_legal", 32'(head_peek_rdy & head_remove_rdy), 32'd1);
        chk("alloc_stall", 32'(alloc_stall), 32'(mode != 0));
        chk("commit_call", 32'(commit_call), 32'(exp_q.size() != 0));
        if (prev_stalled)
            chk("stall_hold", 32'(commit_value), 32'(prev_value));
        case (mode)
            0: begin
                exp_rm = head_peek_rdy && rrdy && h[15] &&
                         (h[14] ? (exp_q.size() == 0) : (exp_q.size() == 0 || crdy));
                chk("remove_run", 32'(head_remove_call), 32'(exp_rm));
                chk("flush_call", 32'(flush_call), 32'(exp_rm && h[14]));
            end
            1: begin
                exp_rm = head_peek_rdy && rrdy;
                chk("remove_drain", 32'(head_remove_call), 32'(exp_rm));
                chk("flush_call_drain", 32'(flush_call), 32'd0);
            end
            default: begin
                chk("remove_flush", 32'(head_remove_call), 32'd0);
                chk("flush_call_flush", 32'(flush_call), 32'd0);
            end
        endcase
        if (commit_call && crdy && exp_q.size() != 0) begin
            want = exp_q.pop_front();
            chk("commit_value", 32'(commit_value), 32'(want));
            commit_cycles.push_back(cycle);
        end
        if (head_remove_call && buf_q.size() != 0) begin
            void'(buf_q.pop_front());
            if (mode == 0 && !h[14]) begin
                exp_q.push_back(h[13:0]);
                exp_ret++;
            end else begin
                exp_fl++;
                if (mode == 0) next_mode = 1;
            end
        end
        if (mode == 1 && !head_peek_rdy) next_mode = 2;
        if (mode == 2) next_mode = 0;
        prev_stalled = commit_call && !crdy;
        prev_value   = commit_value;
        mode         = next_mode;
        @(posedge clk);
        #1;
        chk("retired_count", 32'(retired_count), 32'(16'(exp_ret)));
        chk("flushed_count", 32'(flushed_count), 32'(16'(exp_fl)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        buf_q.delete();
        exp_q.delete();
        mode = 0;
        exp_ret = 0;
        exp_fl = 0;
        prev_stalled = 1'b0;
        chk("rst_commit_call", 32'(commit_call), 32'd0);
        chk("rst_alloc_stall", 32'(alloc_stall), 32'd0);
        chk("rst_flush_call", 32'(flush_call), 32'd0);
        chk("rst_retired", 32'(retired_count), 32'd0);
        chk("rst_flushed", 32'(flushed_count), 32'd0);
        head_peek_rdy = 1'b0;
        #1;
        chk("rst_remove", 32'(head_remove_call), 32'd0);
    endtask

    initial begin
        logic [15:0] e;
        int r;

        // Reset, empty buffer
        do_reset();
        step(1'b1, 1'b1);
        chk("t027_commit_call", 32'(commit_call), 32'd0);

        // Three done heads retire back to back
        buf_q.push_back(16'h8001);
        buf_q.push_back(16'h8002);
        buf_q.push_back(16'h8003);
        commit_cycles.delete();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
        chk("t028_ncommits", 32'(commit_cycles.size()), 32'd3);
        if (commit_cycles.size() == 3)
            chk("t028_consecutive", 32'(commit_cycles[2] - commit_cycles[0]), 32'd2);
        chk("t028_retired", 32'(retired_count), 32'd3);

        // Consumer stall holds the output and blocks the next head
        buf_q.push_back(16'h8005);
        buf_q.push_back(16'h8006);
        step(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1);
            chk("t029_value", 32'(commit_value), 32'h5);
            chk("t029_head_kept", 32'(buf_q.size()), 32'd1);
        end
        step(1'b1, 1'b1);
        chk("t029_head_taken", 32'(buf_q.size()), 32'd0);
        step(1'b1, 1'b1);

        // Not-done head waits in place
        buf_q.push_back(16'h0007);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
        chk("t030_wait", 32'(buf_q.size()), 32'd1);
        buf_q[0] = 16'h8007;
        step(1'b1, 1'b1);
        chk("t030_removed", 32'(buf_q.size()), 32'd0);
        step(1'b1, 1'b1);
        chk("t030_retired", 32'(retired_count), 32'd6);

        // Exception behind a pending commit, then drain and flush
        buf_q.push_back(16'h8010);
        step(1'b0, 1'b1);
        buf_q.push_back(16'hC011);
        buf_q.push_back(16'h8012);
        buf_q.push_back(16'h8013);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("t031_exc_waits", 32'(buf_q.size()), 32'd3);
        step(1'b1, 1'b1);
        chk("t031_exc_waits_accept", 32'(buf_q.size()), 32'd3);
        step(1'b1, 1'b1);
        chk("t031_flushed1", 32'(flushed_count), 32'd1);
        chk("t031_stall_drain", 32'(alloc_stall), 32'd1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("t031_flushed3", 32'(flushed_count), 32'd3);
        step(1'b1, 1'b1);
        chk("t031_stall_flush", 32'(alloc_stall), 32'd1);
        step(1'b1, 1'b1);
        chk("t031_back_run", 32'(alloc_stall), 32'd0);
        chk("t031_retired", 32'(retired_count), 32'd7);

        // Reset while draining
        buf_q.push_back(16'hC020);
        buf_q.push_back(16'h8021);
        buf_q.push_back(16'h8022);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        chk("t032_in_drain", 32'(alloc_stall), 32'd1);
        do_reset();
        step(1'b1, 1'b1);
        chk("t032_run", 32'(alloc_stall), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            if (mode == 0 && buf_q.size() < 8 && $urandom_range(0, 1) == 1) begin
                r = int'($urandom_range(0, 19));
                e = {2'b00, 14'($urandom)};
                if (r == 0)      e[15:14] = 2'b11;
                else if (r >= 4) e[15] = 1'b1;
                buf_q.push_back(e);
            end
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            for (int i = 0; i < buf_q.size(); i++) begin
                if (!buf_q[i][15] && $urandom_range(0, 3) == 0) begin
                    e = buf_q[i];
                    e[15] = 1'b1;
                    buf_q[i] = e;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
